// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared write-back types, default sizes and functional-unit indices for the GPR write-back path.
package gpr_wb_arbiter_pkg;

    localparam int unsigned NUM_FU_DEF  = 4;
    localparam int unsigned GPR_ASZ_DEF = 5;
    localparam int unsigned RSZ_DEF     = 32;
    localparam int unsigned MAX_GPR_DEF = 32;
    localparam int unsigned SRC_W_DEF   = $clog2(NUM_FU_DEF);

    localparam int unsigned FU_ALU = 0;
    localparam int unsigned FU_MDU = 1;
    localparam int unsigned FU_LSU = 2;
    localparam int unsigned FU_CSR = 3;

    typedef struct packed {
        logic [GPR_ASZ_DEF-1:0] rd;
        logic [RSZ_DEF-1:0]     data;
    } wb_req_t;

    typedef struct packed {
        logic                   valid;
        logic [GPR_ASZ_DEF-1:0] rd;
        logic [RSZ_DEF-1:0]     data;
        logic [SRC_W_DEF-1:0]   src;
    } wb_stage_t;

    // Wraps a search position that has run at most one lap past n back into 0..n-1.
    function automatic int unsigned ptr_wrap(input int unsigned v, input int unsigned n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 any_c
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] pos;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        pos     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = IW'(ptr_wrap(32'(ptr) + off, N));
            if (!any_c && req[pos]) begin
                any_c        = 1'b1;
                idx_c        = pos;
                grant_c[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter from NUM_FU functional units into the single GPR write port.
// Optional operand-forwarding outputs are built when WB_FWD_EN is defined.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU  = NUM_FU_DEF,
    parameter int unsigned GPR_ASZ = GPR_ASZ_DEF,
    parameter int unsigned RSZ     = RSZ_DEF,
    parameter int unsigned MAX_GPR = MAX_GPR_DEF
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [NUM_FU-1:0]           fu_valid_in,
    output logic [NUM_FU-1:0]           fu_rdy_out,
    input  logic [NUM_FU*GPR_ASZ-1:0]   fu_rd_in,
    input  logic [NUM_FU*RSZ-1:0]       fu_data_in,
    input  logic                        wb_rdy_in,
    output logic [MAX_GPR-1:0]          gpr_wr_out,
    output logic [MAX_GPR*RSZ-1:0]      gpr_wr_data_out,
`ifdef WB_FWD_EN
    output logic                        fwd_valid_out,
    output logic [GPR_ASZ-1:0]          fwd_rd_out,
    output logic [RSZ-1:0]              fwd_data_out,
`endif
    output logic                        wb_valid_out,
    output logic [GPR_ASZ-1:0]          wb_rd_out,
    output logic [$clog2(NUM_FU)-1:0]   wb_src_out
);

    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [SRC_W-1:0]  rr_ptr;
    logic [RSZ-1:0]    wb_data;
    logic [NUM_FU-1:0] win_grant_c;
    logic [SRC_W-1:0]  win_idx_c;
    logic              win_any_c;
    logic              can_load_c;
    logic              xfer_c;
    logic              drain_c;
    logic [GPR_ASZ-1:0] sel_rd_c;
    logic [RSZ-1:0]     sel_data_c;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req     (fu_valid_in),
        .ptr     (rr_ptr),
        .grant_c (win_grant_c),
        .idx_c   (win_idx_c),
        .any_c   (win_any_c)
    );

    // Reset gating keeps the FU side quiet while the stage is held in reset.
    assign drain_c    = wb_valid_out & wb_rdy_in;
    assign can_load_c = ~wb_valid_out | wb_rdy_in;
    assign xfer_c     = win_any_c & can_load_c & reset_in;
    assign fu_rdy_out = xfer_c ? win_grant_c : '0;

    always_comb begin
        sel_rd_c   = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (win_idx_c == SRC_W'(i)) begin
                sel_rd_c   = fu_rd_in[i*GPR_ASZ +: GPR_ASZ];
                sel_data_c = fu_data_in[i*RSZ +: RSZ];
            end
        end
    end

    // Output stage: a new winner may replace an entry that drains in the same cycle.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wb_valid_out <= 1'b0;
            wb_rd_out    <= '0;
            wb_data      <= '0;
            wb_src_out   <= '0;
            rr_ptr       <= '0;
        end else if (xfer_c) begin
            wb_valid_out <= 1'b1;
            wb_rd_out    <= sel_rd_c;
            wb_data      <= sel_data_c;
            wb_src_out   <= win_idx_c;
            rr_ptr       <= (win_idx_c == SRC_W'(NUM_FU - 1)) ? '0 : win_idx_c + SRC_W'(1);
        end else if (drain_c) begin
            wb_valid_out <= 1'b0;
        end
    end

    // x0 is never written; the result is still drained.
    assign gpr_wr_out[0] = 1'b0;
    for (genvar g = 1; g < MAX_GPR; g++) begin : g_wr
        assign gpr_wr_out[g] = drain_c & (wb_rd_out == GPR_ASZ'(g));
    end

    assign gpr_wr_data_out = {MAX_GPR{wb_data}};

`ifdef WB_FWD_EN
    assign fwd_valid_out = wb_valid_out & (wb_rd_out != '0);
    assign fwd_rd_out    = wb_rd_out;
    assign fwd_data_out  = wb_data;
`endif

endmodule
